// File: rtl/per2axi_req_channel_if.sv
// Bus bundle between the peripheral interconnect, the request channel and the AXI fabric.
// Contents: peripheral slave request/grant, AXI AW/W/AR request channels, and the
// read-transaction notification consumed by the response channel.
// Modports: master = the bridge request channel (drives gnt, AXI requests, trans_*),
//           slave  = the surrounding environment (drives requests and AXI readies).
interface per2axi_req_channel_if #(
  parameter int unsigned PER_ADDR_WIDTH = 32,
  parameter int unsigned PER_ID_WIDTH   = 5,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned AXI_ID_WIDTH   = 3
);
  // Peripheral slave port
  logic                      per_slave_req_i;
  logic [PER_ADDR_WIDTH-1:0] per_slave_add_i;
  logic                      per_slave_we_i;
  logic [31:0]               per_slave_wdata_i;
  logic [3:0]                per_slave_be_i;
  logic [PER_ID_WIDTH-1:0]   per_slave_id_i;
  logic                      per_slave_gnt_o;

  // AXI write address channel
  logic                      axi_master_aw_valid_o;
  logic [AXI_ADDR_WIDTH-1:0] axi_master_aw_addr_o;
  logic [2:0]                axi_master_aw_prot_o;
  logic [3:0]                axi_master_aw_region_o;
  logic [7:0]                axi_master_aw_len_o;
  logic [2:0]                axi_master_aw_size_o;
  logic [1:0]                axi_master_aw_burst_o;
  logic                      axi_master_aw_lock_o;
  logic [3:0]                axi_master_aw_cache_o;
  logic [3:0]                axi_master_aw_qos_o;
  logic [AXI_ID_WIDTH-1:0]   axi_master_aw_id_o;
  logic [AXI_USER_WIDTH-1:0] axi_master_aw_user_o;
  logic                      axi_master_aw_ready_i;

  // AXI read address channel
  logic                      axi_master_ar_valid_o;
  logic [AXI_ADDR_WIDTH-1:0] axi_master_ar_addr_o;
  logic [2:0]                axi_master_ar_prot_o;
  logic [3:0]                axi_master_ar_region_o;
  logic [7:0]                axi_master_ar_len_o;
  logic [2:0]                axi_master_ar_size_o;
  logic [1:0]                axi_master_ar_burst_o;
  logic                      axi_master_ar_lock_o;
  logic [3:0]                axi_master_ar_cache_o;
  logic [3:0]                axi_master_ar_qos_o;
  logic [AXI_ID_WIDTH-1:0]   axi_master_ar_id_o;
  logic [AXI_USER_WIDTH-1:0] axi_master_ar_user_o;
  logic                      axi_master_ar_ready_i;

  // AXI write data channel
  logic                      axi_master_w_valid_o;
  logic [63:0]               axi_master_w_data_o;
  logic [7:0]                axi_master_w_strb_o;
  logic [AXI_USER_WIDTH-1:0] axi_master_w_user_o;
  logic                      axi_master_w_last_o;
  logic                      axi_master_w_ready_i;

  // Read notification towards the response channel
  logic                      trans_req_o;
  logic [AXI_ID_WIDTH-1:0]   trans_id_o;
  logic [AXI_ADDR_WIDTH-1:0] trans_add_o;

  modport master (
    input  per_slave_req_i, per_slave_add_i, per_slave_we_i, per_slave_wdata_i,
           per_slave_be_i, per_slave_id_i,
    output per_slave_gnt_o,
    output axi_master_aw_valid_o, axi_master_aw_addr_o, axi_master_aw_prot_o,
           axi_master_aw_region_o, axi_master_aw_len_o, axi_master_aw_size_o,
           axi_master_aw_burst_o, axi_master_aw_lock_o, axi_master_aw_cache_o,
           axi_master_aw_qos_o, axi_master_aw_id_o, axi_master_aw_user_o,
    input  axi_master_aw_ready_i,
    output axi_master_ar_valid_o, axi_master_ar_addr_o, axi_master_ar_prot_o,
           axi_master_ar_region_o, axi_master_ar_len_o, axi_master_ar_size_o,
           axi_master_ar_burst_o, axi_master_ar_lock_o, axi_master_ar_cache_o,
           axi_master_ar_qos_o, axi_master_ar_id_o, axi_master_ar_user_o,
    input  axi_master_ar_ready_i,
    output axi_master_w_valid_o, axi_master_w_data_o, axi_master_w_strb_o,
           axi_master_w_user_o, axi_master_w_last_o,
    input  axi_master_w_ready_i,
    output trans_req_o, trans_id_o, trans_add_o
  );

  modport slave (
    output per_slave_req_i, per_slave_add_i, per_slave_we_i, per_slave_wdata_i,
           per_slave_be_i, per_slave_id_i,
    input  per_slave_gnt_o,
    input  axi_master_aw_valid_o, axi_master_aw_addr_o, axi_master_aw_prot_o,
           axi_master_aw_region_o, axi_master_aw_len_o, axi_master_aw_size_o,
           axi_master_aw_burst_o, axi_master_aw_lock_o, axi_master_aw_cache_o,
           axi_master_aw_qos_o, axi_master_aw_id_o, axi_master_aw_user_o,
    output axi_master_aw_ready_i,
    input  axi_master_ar_valid_o, axi_master_ar_addr_o, axi_master_ar_prot_o,
           axi_master_ar_region_o, axi_master_ar_len_o, axi_master_ar_size_o,
           axi_master_ar_burst_o, axi_master_ar_lock_o, axi_master_ar_cache_o,
           axi_master_ar_qos_o, axi_master_ar_id_o, axi_master_ar_user_o,
    output axi_master_ar_ready_i,
    input  axi_master_w_valid_o, axi_master_w_data_o, axi_master_w_strb_o,
           axi_master_w_user_o, axi_master_w_last_o,
    output axi_master_w_ready_i,
    input  trans_req_o, trans_id_o, trans_add_o
  );
endinterface

// File: rtl/per2axi_req_channel.sv
// Request half of the peripheral-to-AXI bridge: accepts one 32-bit peripheral request at a
// time and issues it as a single-beat AXI4 read (AR) or write (AW + W). Reads also raise a
// trans_* notification so the response channel can pick the right 32-bit half of R data.
// Ports: clk_i, rst_i (synchronous, active-high), bus (master modport of the bridge bundle).
module per2axi_req_channel #(
  parameter int unsigned NB_CORES       = 4,
  parameter int unsigned PER_ADDR_WIDTH = 32,
  parameter int unsigned PER_ID_WIDTH   = 5,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned AXI_ID_WIDTH   = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  per2axi_req_channel_if.master  bus
);

  localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

  // Parameter sanity checks at elaboration time
  if (PER_ID_WIDTH < NB_CORES) begin : g_chk_id_width
    $error("PER_ID_WIDTH must be >= NB_CORES");
  end
  if (AXI_ADDR_WIDTH != PER_ADDR_WIDTH) begin : g_chk_addr_width
    $error("AXI_ADDR_WIDTH must equal PER_ADDR_WIDTH");
  end
  if (AXI_DATA_WIDTH != 64) begin : g_chk_data_width
    $error("AXI_DATA_WIDTH must be 64");
  end
  if ((1 << AXI_ID_WIDTH) < PER_ID_WIDTH) begin : g_chk_axi_id
    $error("2**AXI_ID_WIDTH must be >= PER_ID_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

  state_e                    state_q, state_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic                      ar_valid_q, aw_valid_q, w_valid_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [31:0]               wdata_q;
  logic [STRB_WIDTH-1:0]     strb_q;

  logic                      gnt_c;
  logic                      trans_req_c;
  logic [AXI_ID_WIDTH-1:0]   id_c;
  logic [STRB_WIDTH-1:0]     strb_c;
  logic                      ar_hs, aw_hs, w_hs;

  // Lowest set bit of the one-hot initiator ID; the descending scan lets the lowest win
  always_comb begin
    id_c = '0;
    for (int i = PER_ID_WIDTH - 1; i >= 0; i--) begin
      if (bus.per_slave_id_i[i]) id_c = AXI_ID_WIDTH'(i);
    end
  end

  // A 32-bit word lands in the upper or lower half of the 64-bit beat depending on add[2]
  assign strb_c = bus.per_slave_add_i[2] ? {bus.per_slave_be_i, 4'b0000}
                                         : {4'b0000, bus.per_slave_be_i};

  assign ar_hs = ar_valid_q & bus.axi_master_ar_ready_i;
  assign aw_hs = aw_valid_q & bus.axi_master_aw_ready_i;
  assign w_hs  = w_valid_q  & bus.axi_master_w_ready_i;

  // Next state, handshake bookkeeping, grant and read notification
  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    gnt_c       = 1'b0;
    trans_req_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        gnt_c     = bus.per_slave_req_i;
        if (bus.per_slave_req_i) state_d = bus.per_slave_we_i ? READ : WRITE;
      end
      READ: begin
        if (ar_hs) begin
          trans_req_c = 1'b1;
          state_d     = IDLE;
        end
      end
      WRITE: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q  | w_hs;
        if (aw_done_d && w_done_d) begin
          state_d   = IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // A grant or notification in the reset cycle would be lost, so suppress it
    if (rst_i) begin
      gnt_c       = 1'b0;
      trans_req_c = 1'b0;
    end
  end

  // State, valid and payload registers; payload only loads on a grant so it is stable under valid
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      ar_valid_q <= 1'b0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      addr_q     <= '0;
      id_q       <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
    end else begin
      state_q    <= state_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      ar_valid_q <= (state_d == READ);
      aw_valid_q <= (state_d == WRITE) && !aw_done_d;
      w_valid_q  <= (state_d == WRITE) && !w_done_d;
      if (gnt_c) begin
        addr_q  <= AXI_ADDR_WIDTH'(bus.per_slave_add_i);
        id_q    <= id_c;
        wdata_q <= bus.per_slave_wdata_i;
        strb_q  <= strb_c;
      end
    end
  end

  assign bus.per_slave_gnt_o        = gnt_c;

  assign bus.axi_master_aw_valid_o  = aw_valid_q;
  assign bus.axi_master_aw_addr_o   = addr_q;
  assign bus.axi_master_aw_prot_o   = 3'b000;
  assign bus.axi_master_aw_region_o = 4'b0000;
  assign bus.axi_master_aw_len_o    = 8'h00;
  assign bus.axi_master_aw_size_o   = 3'b010;
  assign bus.axi_master_aw_burst_o  = 2'b01;
  assign bus.axi_master_aw_lock_o   = 1'b0;
  assign bus.axi_master_aw_cache_o  = 4'b0000;
  assign bus.axi_master_aw_qos_o    = 4'b0000;
  assign bus.axi_master_aw_id_o     = id_q;
  assign bus.axi_master_aw_user_o   = '0;

  assign bus.axi_master_ar_valid_o  = ar_valid_q;
  assign bus.axi_master_ar_addr_o   = addr_q;
  assign bus.axi_master_ar_prot_o   = 3'b000;
  assign bus.axi_master_ar_region_o = 4'b0000;
  assign bus.axi_master_ar_len_o    = 8'h00;
  assign bus.axi_master_ar_size_o   = 3'b010;
  assign bus.axi_master_ar_burst_o  = 2'b01;
  assign bus.axi_master_ar_lock_o   = 1'b0;
  assign bus.axi_master_ar_cache_o  = 4'b0000;
  assign bus.axi_master_ar_qos_o    = 4'b0000;
  assign bus.axi_master_ar_id_o     = id_q;
  assign bus.axi_master_ar_user_o   = '0;

  assign bus.axi_master_w_valid_o   = w_valid_q;
  assign bus.axi_master_w_data_o    = {wdata_q, wdata_q};
  assign bus.axi_master_w_strb_o    = strb_q;
  assign bus.axi_master_w_user_o    = '0;
  assign bus.axi_master_w_last_o    = 1'b1;

  assign bus.trans_req_o            = trans_req_c;
  assign bus.trans_id_o             = id_q;
  assign bus.trans_add_o            = addr_q;

endmodule

// File: tb/tb_per2axi_req_channel.sv
// Directed bench for per2axi_req_channel: a vector table for single read/write transactions
// with all readies high, plus hand-written sequences for skewed write handshakes, AR
// backpressure with a pending request, and reset in the middle of a write.
module tb_per2axi_req_channel;

  logic clk = 1'b0;
  logic rst_i;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  per2axi_req_channel_if #(
    .PER_ADDR_WIDTH(32), .PER_ID_WIDTH(5), .AXI_ADDR_WIDTH(32),
    .AXI_USER_WIDTH(6), .AXI_ID_WIDTH(3)
  ) bus ();

  per2axi_req_channel #(
    .NB_CORES(4), .PER_ADDR_WIDTH(32), .PER_ID_WIDTH(5), .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(64), .AXI_USER_WIDTH(6), .AXI_ID_WIDTH(3)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] add;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [4:0]  id;
    logic [2:0]  exp_id;
    logic [7:0]  exp_strb;
    logic [63:0] exp_wdata;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.per_slave_req_i   = 1'b0;
    bus.per_slave_we_i    = 1'b0;
    bus.per_slave_add_i   = '0;
    bus.per_slave_wdata_i = '0;
    bus.per_slave_be_i    = '0;
    bus.per_slave_id_i    = '0;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] add, input logic [31:0] wdata,
                           input logic [3:0] be, input logic [4:0] id);
    bus.per_slave_req_i   = 1'b1;
    bus.per_slave_we_i    = we;
    bus.per_slave_add_i   = add;
    bus.per_slave_wdata_i = wdata;
    bus.per_slave_be_i    = be;
    bus.per_slave_id_i    = id;
  endtask

  task automatic set_ready(input logic ar, input logic aw, input logic w);
    bus.axi_master_ar_ready_i = ar;
    bus.axi_master_aw_ready_i = aw;
    bus.axi_master_w_ready_i  = w;
  endtask

  function automatic logic [63:0] valids();
    return 64'({bus.axi_master_ar_valid_o, bus.axi_master_aw_valid_o, bus.axi_master_w_valid_o});
  endfunction

  initial begin
    //           we    add           wdata         be       id        id    strb   w_data
    vecs[0] = '{1'b1, 32'h1000_0004, 32'h0,        4'h0, 5'b00100, 3'd2, 8'h00, 64'h0};
    vecs[1] = '{1'b0, 32'h1000_0000, 32'hCAFEBABE, 4'h3, 5'b00001, 3'd0, 8'h03, 64'hCAFEBABE_CAFEBABE};
    vecs[2] = '{1'b0, 32'h1000_0004, 32'hCAFEBABE, 4'h3, 5'b00010, 3'd1, 8'h30, 64'hCAFEBABE_CAFEBABE};
    vecs[3] = '{1'b1, 32'h2000_0008, 32'h0,        4'h0, 5'b00000, 3'd0, 8'h00, 64'h0};
    vecs[4] = '{1'b1, 32'h2000_0010, 32'h0,        4'h0, 5'b01010, 3'd1, 8'h00, 64'h0};
    vecs[5] = '{1'b0, 32'h0000_000C, 32'h1234_5678, 4'hF, 5'b10000, 3'd4, 8'hF0, 64'h12345678_12345678};
    vecs[6] = '{1'b0, 32'h0000_0030, 32'hDEAD_BEEF, 4'h9, 5'b01000, 3'd3, 8'h09, 64'hDEADBEEF_DEADBEEF};

    // Reset with a request pending: nothing may be granted or issued
    rst_i = 1'b1;
    idle_inputs();
    set_ready(1'b1, 1'b1, 1'b1);
    drive_req(1'b1, 32'h1, 32'h0, 4'h0, 5'b00001);
    next_cycle();
    next_cycle();
    check("reset_gnt", 64'(bus.per_slave_gnt_o), 64'd0);
    check("reset_valids", valids(), 64'd0);
    check("reset_trans_req", 64'(bus.trans_req_o), 64'd0);
    idle_inputs();
    next_cycle();
    rst_i = 1'b0;
    next_cycle();

    // Single transactions with every ready held high
    foreach (vecs[k]) begin
      drive_req(vecs[k].we, vecs[k].add, vecs[k].wdata, vecs[k].be, vecs[k].id);
      #1;
      check($sformatf("v%0d_gnt", k), 64'(bus.per_slave_gnt_o), 64'd1);
      next_cycle();
      idle_inputs();
      #1;
      if (vecs[k].we) begin
        check($sformatf("v%0d_valids", k), valids(), 64'b100);
        check($sformatf("v%0d_ar_addr", k), 64'(bus.axi_master_ar_addr_o), 64'(vecs[k].add));
        check($sformatf("v%0d_ar_id", k), 64'(bus.axi_master_ar_id_o), 64'(vecs[k].exp_id));
        check($sformatf("v%0d_trans_req", k), 64'(bus.trans_req_o), 64'd1);
        check($sformatf("v%0d_trans_id", k), 64'(bus.trans_id_o), 64'(vecs[k].exp_id));
        check($sformatf("v%0d_trans_add", k), 64'(bus.trans_add_o), 64'(vecs[k].add));
        check($sformatf("v%0d_ar_fixed", k),
              64'({bus.axi_master_ar_len_o, bus.axi_master_ar_size_o, bus.axi_master_ar_burst_o,
                   bus.axi_master_ar_lock_o, bus.axi_master_ar_cache_o, bus.axi_master_ar_prot_o,
                   bus.axi_master_ar_region_o, bus.axi_master_ar_qos_o, bus.axi_master_ar_user_o}),
              64'({8'h00, 3'b010, 2'b01, 1'b0, 4'h0, 3'h0, 4'h0, 4'h0, 6'h0}));
      end else begin
        check($sformatf("v%0d_valids", k), valids(), 64'b011);
        check($sformatf("v%0d_aw_addr", k), 64'(bus.axi_master_aw_addr_o), 64'(vecs[k].add));
        check($sformatf("v%0d_aw_id", k), 64'(bus.axi_master_aw_id_o), 64'(vecs[k].exp_id));
        check($sformatf("v%0d_w_data", k), bus.axi_master_w_data_o, vecs[k].exp_wdata);
        check($sformatf("v%0d_w_strb", k), 64'(bus.axi_master_w_strb_o), 64'(vecs[k].exp_strb));
        check($sformatf("v%0d_trans_req", k), 64'(bus.trans_req_o), 64'd0);
        check($sformatf("v%0d_aw_fixed", k),
              64'({bus.axi_master_aw_len_o, bus.axi_master_aw_size_o, bus.axi_master_aw_burst_o,
                   bus.axi_master_aw_lock_o, bus.axi_master_aw_cache_o, bus.axi_master_aw_prot_o,
                   bus.axi_master_aw_region_o, bus.axi_master_aw_qos_o, bus.axi_master_aw_user_o,
                   bus.axi_master_w_last_o, bus.axi_master_w_user_o}),
              64'({8'h00, 3'b010, 2'b01, 1'b0, 4'h0, 3'h0, 4'h0, 4'h0, 6'h0, 1'b1, 6'h0}));
      end
      next_cycle();
      check($sformatf("v%0d_idle_valids", k), valids(), 64'd0);
    end

    // Skewed write: AW handshakes at cycle 1, W at cycle 4, a read waits behind it
    set_ready(1'b1, 1'b0, 1'b0);
    drive_req(1'b0, 32'h0000_0040, 32'h1111_2222, 4'hF, 5'b00001);
    #1;
    check("skew_c0_gnt", 64'(bus.per_slave_gnt_o), 64'd1);
    next_cycle();
    drive_req(1'b1, 32'h5000_0010, 32'h0, 4'h0, 5'b00100);
    bus.axi_master_aw_ready_i = 1'b1;
    #1;
    check("skew_c1_valids", valids(), 64'b011);
    check("skew_c1_gnt", 64'(bus.per_slave_gnt_o), 64'd0);
    for (int c = 2; c <= 4; c++) begin
      next_cycle();
      bus.axi_master_aw_ready_i = 1'b0;
      bus.axi_master_w_ready_i  = (c == 4);
      #1;
      check($sformatf("skew_c%0d_valids", c), valids(), 64'b001);
      check($sformatf("skew_c%0d_gnt", c), 64'(bus.per_slave_gnt_o), 64'd0);
      check($sformatf("skew_c%0d_w_data", c), bus.axi_master_w_data_o, 64'h11112222_11112222);
    end
    next_cycle();
    bus.axi_master_w_ready_i = 1'b0;
    #1;
    check("skew_c5_valids", valids(), 64'd0);
    check("skew_c5_gnt", 64'(bus.per_slave_gnt_o), 64'd1);
    next_cycle();
    idle_inputs();
    #1;
    check("skew_c6_valids", valids(), 64'b100);
    check("skew_c6_ar_addr", 64'(bus.axi_master_ar_addr_o), 64'h5000_0010);
    check("skew_c6_trans_id", 64'(bus.trans_id_o), 64'd2);
    check("skew_c6_trans_req", 64'(bus.trans_req_o), 64'd1);
    next_cycle();
    check("skew_c7_valids", valids(), 64'd0);

    // AR backpressure for 6 cycles with a second read pending
    set_ready(1'b0, 1'b1, 1'b1);
    drive_req(1'b1, 32'h6000_0020, 32'h0, 4'h0, 5'b01000);
    #1;
    check("bp_c0_gnt", 64'(bus.per_slave_gnt_o), 64'd1);
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      drive_req(1'b1, 32'h7000_0030, 32'h0, 4'h0, 5'b00010);
      #1;
      check($sformatf("bp_c%0d_valids", c), valids(), 64'b100);
      check($sformatf("bp_c%0d_ar", c),
            64'({bus.axi_master_ar_id_o, bus.axi_master_ar_addr_o}), 64'({3'd3, 32'h6000_0020}));
      check($sformatf("bp_c%0d_gnt", c), 64'(bus.per_slave_gnt_o), 64'd0);
      check($sformatf("bp_c%0d_trans_req", c), 64'(bus.trans_req_o), 64'd0);
    end
    next_cycle();
    bus.axi_master_ar_ready_i = 1'b1;
    #1;
    check("bp_c7_trans_req", 64'(bus.trans_req_o), 64'd1);
    check("bp_c7_trans_add", 64'(bus.trans_add_o), 64'h6000_0020);
    check("bp_c7_gnt", 64'(bus.per_slave_gnt_o), 64'd0);
    next_cycle();
    check("bp_c8_valids", valids(), 64'd0);
    check("bp_c8_gnt", 64'(bus.per_slave_gnt_o), 64'd1);
    next_cycle();
    idle_inputs();
    #1;
    check("bp_c9_ar", 64'({bus.axi_master_ar_id_o, bus.axi_master_ar_addr_o}),
          64'({3'd1, 32'h7000_0030}));
    check("bp_c9_trans_req", 64'(bus.trans_req_o), 64'd1);
    next_cycle();
    check("bp_c10_valids", valids(), 64'd0);

    // Reset while in WRITE after AW already handshaked
    set_ready(1'b1, 1'b1, 1'b0);
    drive_req(1'b0, 32'h8000_0004, 32'hA5A5_A5A5, 4'hC, 5'b00100);
    #1;
    check("rst_c0_gnt", 64'(bus.per_slave_gnt_o), 64'd1);
    next_cycle();
    idle_inputs();
    #1;
    check("rst_c1_valids", valids(), 64'b011);
    next_cycle();
    bus.axi_master_aw_ready_i = 1'b0;
    #1;
    check("rst_c2_valids", valids(), 64'b001);
    rst_i = 1'b1;
    next_cycle();
    rst_i = 1'b0;
    #1;
    check("rst_c3_valids", valids(), 64'd0);
    drive_req(1'b0, 32'h9000_0000, 32'h0BAD_F00D, 4'h1, 5'b00010);
    #1;
    check("rst_c3_gnt", 64'(bus.per_slave_gnt_o), 64'd1);
    next_cycle();
    idle_inputs();
    #1;
    check("rst_c4_valids", valids(), 64'b011);
    check("rst_c4_aw", 64'({bus.axi_master_aw_id_o, bus.axi_master_aw_addr_o}),
          64'({3'd1, 32'h9000_0000}));
    check("rst_c4_w_strb", 64'(bus.axi_master_w_strb_o), 64'h01);
    check("rst_c4_w_data", bus.axi_master_w_data_o, 64'h0BADF00D_0BADF00D);
    set_ready(1'b1, 1'b1, 1'b1);
    next_cycle();
    check("rst_c5_valids", valids(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
